// File: rtl/rps_pkg.sv
// Shared move encodings, FSM state type and small helpers for the
// rock-paper-scissors move capture block.
package rps_pkg;

  localparam logic [2:0] MV_NONE     = 3'b000;
  localparam logic [2:0] MV_ROCK     = 3'b001;
  localparam logic [2:0] MV_SCISSORS = 3'b010;
  localparam logic [2:0] MV_PAPER    = 3'b100;

  localparam logic [7:0] LFSR_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    WAIT_REL,
    CLEAR
  } state_t;

  // Computer move chosen from the LFSR value modulo 3.
  function automatic logic [2:0] lfsr_move(input logic [7:0] value);
    logic [7:0] rem;
    rem = value % 8'd3;
    case (rem)
      8'd0:    return MV_ROCK;
      8'd1:    return MV_SCISSORS;
      default: return MV_PAPER;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [2:0] mv);
    return (mv == MV_ROCK) || (mv == MV_SCISSORS) || (mv == MV_PAPER);
  endfunction

endpackage

// File: rtl/move_capture_if.sv
// Button inputs and captured-round outputs of move_capture.
interface move_capture_if;
  logic [2:0] BTN;
  logic [2:0] user;
  logic [2:0] compu;
  logic       round_valid;
  logic       busy;

  modport master (output BTN, input user, compu, round_valid, busy);
  modport slave  (input BTN, output user, compu, round_valid, busy);
endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce counter
// for one raw button bit.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_reg  <= 2'b00;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      // Any cycle agreeing with the stable level restarts the count.
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/move_capture.sv
// Debounces three move buttons, pairs a one-hot press with an LFSR-derived
// computer move and holds the round on the outputs until release.
module move_capture
  import rps_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 500000
) (
  input logic          CLK,
  input logic          RST_N,
  move_capture_if.slave bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [2:0]    deb;
  logic [7:0]    lfsr_reg;
  logic [HW-1:0] hold_cnt_reg;
  state_t        state_reg;
  logic [2:0]    user_reg;
  logic [2:0]    compu_reg;
  logic          round_valid_reg;
  logic          busy_reg;

  for (genvar gi = 0; gi < 3; gi++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLK  (CLK),
      .RST_N(RST_N),
      .btn  (bus.BTN[gi]),
      .level(deb[gi])
    );
  end

  // Fibonacci form of x^8+x^6+x^5+x^4+1; maximal length so 8'h00 is unreachable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      user_reg        <= MV_NONE;
      compu_reg       <= MV_NONE;
      round_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      round_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          user_reg  <= MV_NONE;
          compu_reg <= MV_NONE;
          if (is_one_hot(deb)) begin
            user_reg        <= deb;
            compu_reg       <= lfsr_move(lfsr_reg);
            round_valid_reg <= 1'b1;
            hold_cnt_reg    <= '0;
            busy_reg        <= 1'b1;
            state_reg       <= SHOW;
          end
        end
        SHOW: begin
          if (hold_cnt_reg == HW'(HOLD_CYCLES - 1)) begin
            state_reg <= WAIT_REL;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end
        WAIT_REL: begin
          if (deb == MV_NONE) begin
            user_reg  <= MV_NONE;
            compu_reg <= MV_NONE;
            state_reg <= CLEAR;
          end
        end
        CLEAR: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.user        = user_reg;
  assign bus.compu       = compu_reg;
  assign bus.round_valid = round_valid_reg;
  assign bus.busy        = busy_reg;

endmodule
